timer_ctrl: RTL and testbench
=============================

# timer_ctrl

- Register-mapped controller that configures and sequences two `counter` instances: Timer A and Timer B.
- Holds the CPU-visible 16-bit start latches, the per-timer control registers and a CIA-style interrupt control register (ICR).
- Drives each counter's `i_cs`/`i_mode`/`i_value`, collects each counter's `o_irq` pulse and merges both into one maskable interrupt line to the CPU.

## Interface

Parameters:
- `ADDR_W`, default 3: register address width.

Ports:
- `i_clk` in 1: system clock.
- `i_reset` in 1: one clock; reset is synchronous and active-low.
- `i_cs` in 1: bus chip select, active-low.
- `i_we` in 1: 1 = write, 0 = read; sampled while `i_cs`=0.
- `i_addr` in ADDR_W: register index.
- `i_data` in 8: write data.
- `o_data` out 8: read data, registered.
- `o_irq` out 1: CPU interrupt, active-high, registered.
- `o_ta_cs` out 1: Timer A counter select. 0 = load/hold, 1 = count.
- `o_ta_mode` out CounterMode: Timer A mode.
- `o_ta_value` out 16: Timer A start value.
- `i_ta_irq` in 1: Timer A alarm pulse.
- `o_tb_cs`, `o_tb_mode`, `o_tb_value`, `i_tb_irq`: same as the Timer A ports, for Timer B.

## Operation

Register map:
- 0 TA_LO, 1 TA_HI, 2 TB_LO, 3 TB_HI: start-latch bytes; reads return the latch contents.
- 4 ICR:
  - Write: bit7 = 1 sets the mask bits given in bits1:0; bit7 = 0 clears them.
  - Read: bit7 = IR (mirrors `o_irq`), bits1:0 = TB/TA flags; bits6:2 read 0.
  - A read clears all flags.
- 5 CRA, 6 CRB (per timer):
  - bit0 START.
  - bit3 RUNMODE: 1 = SINGLE_SHOT, 0 = CONTINUOUS.
  - bit4 FORCELOAD: write-only strobe, reads 0.
  - Other bits read 0.
- 7: reserved. Reads 0, writes ignored.

Per-channel FSM (states STOP, LOAD, RUN):
- STOP: `cs`=0 held.
  - Write with START=1 -> LOAD.
- LOAD: `cs`=0 for exactly one cycle, so the counter captures `value`/`mode`. Next state is RUN.
- RUN: `cs`=1.
  - START written 0 -> STOP.
  - FORCELOAD with START=1 -> LOAD.
  - `irq` with RUNMODE=SINGLE_SHOT -> START cleared, go to STOP.
  - `irq` with CONTINUOUS -> stay in RUN; the counter reloads itself.
- `o_tx_value` continuously reflects the latch. Latch changes during RUN take effect only at the next LOAD.
- `o_tx_mode` reflects RUNMODE.

Interrupts:
- Flag bit N is set on `i_tx_irq`.
- `o_irq` = |(flags & mask), registered.

## Timing

- Reset state:
  - All latches and registers are 0; masks are 0; flags are 0.
  - FSMs are in STOP, so `o_ta_cs`=`o_tb_cs`=0.
  - Modes are CONTINUOUS (RUNMODE=0); values are 0.
  - `o_data`=0 and `o_irq`=0.
- Write is captured on the clock edge where `i_cs`=0 and `i_we`=1. The FSM enters LOAD on the following edge, so `cs` rises 2 cycles after the write edge.
- Read: `o_data` is valid one cycle after the `i_cs`=0/`i_we`=0 sample. The ICR flags clear on that same edge.
- Simultaneous flag set and ICR read-clear: set wins, so the flag remains 1. The value read shows the pre-set flags.
- Single-shot alarm and a START=1 write in the same cycle: the write wins, and the FSM goes to LOAD.
- Mask enabled while a flag is already set: `o_irq` rises on the next edge.
- `i_reset`=0 mid-count forces STOP and `cs`=0 on the next edge, regardless of bus activity.
- Writes to TA/TB latch bytes are byte-wise; there is no high-byte auto-load.

## Configuration

- `GM64_TIMER_B_EN` defined:
  - Channel B is fully present.
- `GM64_TIMER_B_EN` undefined:
  - Registers 2, 3 and 6 read 0 and ignore writes.
  - `o_tb_cs`=0, `o_tb_mode`=CONTINUOUS and `o_tb_value`=0 constantly.
  - `i_tb_irq` is ignored; ICR bit1 flag and mask are tied to 0.

## Structure

- Shared package holds:
  - `CounterMode` (SINGLE_SHOT, CONTINUOUS), shared with `counter`.
  - Channel state enum (chStop, chLoad, chRun).
  - Register address constants and CR/ICR bit-position constants.
- Sub-module `timer_channel`, instantiated once per timer, holds:
  - the latch, the CR register, the FSM and the `cs`/`mode`/`value` outputs;
  - a flag-set output.
- `timer_ctrl` holds:
  - address decode;
  - the ICR (mask, flags, set/clear, read-clear);
  - read mux and `o_irq`.

## Test plan

- Reset, then read all registers -> all read 0. `o_ta_cs`=0, `o_tb_cs`=0, `o_irq`=0.
- Write TA_LO=3 and TA_HI=0, then CRA=0x09 (START, single-shot) -> `o_ta_cs`=0 for one cycle, then 1, with `o_ta_value`=3. When `i_ta_irq` pulses: CRA reads 0x08 and the FSM is in STOP.
- Write CRA=0x01 (continuous), then inject 3 `i_ta_irq` pulses -> `o_ta_cs` stays 1 throughout, and the ICR reads 0x01 before any read-clear.
- Write ICR=0x81, inject `i_ta_irq` -> `o_irq`=1 on the next edge. Read ICR -> returns 0x81; flags clear and `o_irq`=0. Pulse `i_ta_irq` in the read cycle -> the flag stays set.
- Write TA_LO=5 during RUN, then CRA=0x11 (FORCELOAD) -> LOAD pulse (`o_ta_cs`=0 for one cycle) with `o_ta_value`=5.
- Assert `i_reset`=0 while both timers run -> both `cs`=0 and all registers 0 next edge. Without `GM64_TIMER_B_EN`, a write CRB=0x01 -> `o_tb_cs` stays 0 and CRB reads 0.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer controller and its channels.
//   CounterMode   : run mode driven to each counter (shared with `counter`).
//   ch_state_e    : per-channel sequencer state.
//   Addr*         : register indices on the CPU bus.
//   Cr*/Icr*      : bit positions inside the CR and ICR registers.
package timer_ctrl_pkg;

  // Encoding matches the CR RUNMODE bit, so the reset value of CR selects CONTINUOUS.
  typedef enum logic {
    CONTINUOUS  = 1'b0,
    SINGLE_SHOT = 1'b1
  } CounterMode;

  typedef enum logic [1:0] {
    chStop = 2'd0,
    chLoad = 2'd1,
    chRun  = 2'd2
  } ch_state_e;

  localparam int unsigned AddrTaLo = 0;
  localparam int unsigned AddrTaHi = 1;
  localparam int unsigned AddrTbLo = 2;
  localparam int unsigned AddrTbHi = 3;
  localparam int unsigned AddrIcr  = 4;
  localparam int unsigned AddrCra  = 5;
  localparam int unsigned AddrCrb  = 6;
  localparam int unsigned AddrRsvd = 7;

  localparam int unsigned CrStartBit     = 0;
  localparam int unsigned CrRunModeBit   = 3;
  localparam int unsigned CrForceLoadBit = 4;

  localparam int unsigned IcrSetClrBit = 7;
  localparam int unsigned IcrIrBit     = 7;

  // CR readback image: only START and RUNMODE are visible, FORCELOAD is a strobe.
  function automatic logic [7:0] cr_pack(input logic start, input logic runmode);
    logic [7:0] cr;
    cr               = '0;
    cr[CrStartBit]   = start;
    cr[CrRunModeBit] = runmode;
    return cr;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: 16-bit start latch, control register and STOP/LOAD/RUN sequencer.
// Ports:
//   clk_i, rst_ni       : clock, synchronous active-low reset
//   lo_we_i, hi_we_i    : latch byte write strobes (data on wdata_i)
//   cr_we_i             : control register write strobe
//   wdata_i             : bus write data
//   irq_i               : alarm pulse from the counter
//   value_o             : start value to the counter (live latch contents)
//   cr_o                : control register readback
//   mode_o              : counter run mode
//   cs_o                : counter select, 0 = load/hold, 1 = count (registered)
//   flag_set_o          : request to set this channel's ICR flag
module timer_channel
  import timer_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lo_we_i,
  input  logic        hi_we_i,
  input  logic        cr_we_i,
  input  logic [7:0]  wdata_i,
  input  logic        irq_i,
  output logic [15:0] value_o,
  output logic [7:0]  cr_o,
  output CounterMode  mode_o,
  output logic        cs_o,
  output logic        flag_set_o
);

  logic [15:0] latch_q, latch_d;
  logic        start_q, start_d;
  logic        runmode_q, runmode_d;
  logic        force_q, force_d;
  logic        cs_q, cs_d;
  ch_state_e   state_q, state_d;
  logic        single_alarm;

  always_comb begin
    latch_d      = latch_q;
    start_d      = start_q;
    runmode_d    = runmode_q;
    force_d      = 1'b0;
    state_d      = state_q;
    single_alarm = (state_q == chRun) && irq_i && runmode_q;

    if (lo_we_i) latch_d[7:0]  = wdata_i;
    if (hi_we_i) latch_d[15:8] = wdata_i;

    // A single-shot alarm clears START, but a simultaneous CR write overrides it.
    if (single_alarm) start_d = 1'b0;
    if (cr_we_i) begin
      start_d   = wdata_i[CrStartBit];
      runmode_d = wdata_i[CrRunModeBit];
      force_d   = wdata_i[CrForceLoadBit];
    end

    // The sequencer acts on registered CR state, one edge after the write.
    unique case (state_q)
      chStop: if (start_q) state_d = chLoad;
      chLoad: state_d = chRun;
      chRun: begin
        if (single_alarm) begin
          state_d = (cr_we_i && wdata_i[CrStartBit]) ? chLoad : chStop;
        end else if (!start_q) begin
          state_d = chStop;
        end else if (force_q) begin
          state_d = chLoad;
        end
      end
      default: state_d = chStop;
    endcase

    cs_d = (state_d == chRun);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      latch_q   <= '0;
      start_q   <= 1'b0;
      runmode_q <= 1'b0;
      force_q   <= 1'b0;
      state_q   <= chStop;
      cs_q      <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      start_q   <= start_d;
      runmode_q <= runmode_d;
      force_q   <= force_d;
      state_q   <= state_d;
      cs_q      <= cs_d;
    end
  end

  assign value_o    = latch_q;
  assign cr_o       = cr_pack(start_q, runmode_q);
  assign mode_o     = runmode_q ? SINGLE_SHOT : CONTINUOUS;
  assign cs_o       = cs_q;
  assign flag_set_o = irq_i;

endmodule

// File: rtl/timer_ctrl.sv
// Register-mapped controller for two counters (Timer A, Timer B) with a CIA-style ICR.
// Timer B is present only when GM64_TIMER_B_EN is defined; otherwise its registers read 0,
// writes are ignored, its outputs are tied off and its interrupt is ignored.
// Ports:
//   i_clk, i_reset              : clock, synchronous active-low reset
//   i_cs, i_we, i_addr, i_data  : CPU bus (i_cs active-low, i_we 1 = write)
//   o_data                      : registered read data
//   o_irq                       : registered CPU interrupt, active-high
//   o_ta_cs/mode/value, i_ta_irq: Timer A counter interface
//   o_tb_cs/mode/value, i_tb_irq: Timer B counter interface
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cs,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic              o_irq,
  output logic              o_ta_cs,
  output CounterMode        o_ta_mode,
  output logic [15:0]       o_ta_value,
  input  logic              i_ta_irq,
  output logic              o_tb_cs,
  output CounterMode        o_tb_mode,
  output logic [15:0]       o_tb_value,
  input  logic              i_tb_irq
);

`ifdef GM64_TIMER_B_EN
  localparam logic [1:0] ChanMask = 2'b11;
`else
  localparam logic [1:0] ChanMask = 2'b01;
`endif

  logic        wr, rd;
  logic        icr_we, icr_rd;
  logic [7:0]  ta_cr, tb_cr;
  logic [15:0] tb_value;
  logic        ta_set, tb_set;

  logic [1:0]  mask_q, mask_d;
  logic [1:0]  flags_q, flags_d;
  logic        irq_q, irq_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  icr_image;

  assign wr     = !i_cs && i_we;
  assign rd     = !i_cs && !i_we;
  assign icr_we = wr && (i_addr == ADDR_W'(AddrIcr));
  assign icr_rd = rd && (i_addr == ADDR_W'(AddrIcr));

  timer_channel u_chan_a (
    .clk_i      (i_clk),
    .rst_ni     (i_reset),
    .lo_we_i    (wr && (i_addr == ADDR_W'(AddrTaLo))),
    .hi_we_i    (wr && (i_addr == ADDR_W'(AddrTaHi))),
    .cr_we_i    (wr && (i_addr == ADDR_W'(AddrCra))),
    .wdata_i    (i_data),
    .irq_i      (i_ta_irq),
    .value_o    (o_ta_value),
    .cr_o       (ta_cr),
    .mode_o     (o_ta_mode),
    .cs_o       (o_ta_cs),
    .flag_set_o (ta_set)
  );

`ifdef GM64_TIMER_B_EN
  timer_channel u_chan_b (
    .clk_i      (i_clk),
    .rst_ni     (i_reset),
    .lo_we_i    (wr && (i_addr == ADDR_W'(AddrTbLo))),
    .hi_we_i    (wr && (i_addr == ADDR_W'(AddrTbHi))),
    .cr_we_i    (wr && (i_addr == ADDR_W'(AddrCrb))),
    .wdata_i    (i_data),
    .irq_i      (i_tb_irq),
    .value_o    (tb_value),
    .cr_o       (tb_cr),
    .mode_o     (o_tb_mode),
    .cs_o       (o_tb_cs),
    .flag_set_o (tb_set)
  );
`else
  logic unused_tb_irq;
  assign unused_tb_irq = i_tb_irq;
  assign tb_value      = '0;
  assign tb_cr         = '0;
  assign tb_set        = 1'b0;
  assign o_tb_cs       = 1'b0;
  assign o_tb_mode     = CONTINUOUS;
`endif

  assign o_tb_value = tb_value;

  always_comb begin
    icr_image           = '0;
    icr_image[IcrIrBit] = irq_q;
    icr_image[1:0]      = flags_q;

    mask_d = mask_q;
    if (icr_we) begin
      if (i_data[IcrSetClrBit]) mask_d = mask_q | i_data[1:0];
      else                      mask_d = mask_q & ~i_data[1:0];
    end
    mask_d = mask_d & ChanMask;

    // Read-clear first, then set: a flag arriving in the read cycle survives.
    flags_d = icr_rd ? 2'b00 : flags_q;
    flags_d = (flags_d | {tb_set, ta_set}) & ChanMask;

    irq_d = |(flags_d & mask_d);

    rdata_d = rdata_q;
    if (rd) begin
      case (i_addr)
        ADDR_W'(AddrTaLo): rdata_d = o_ta_value[7:0];
        ADDR_W'(AddrTaHi): rdata_d = o_ta_value[15:8];
        ADDR_W'(AddrTbLo): rdata_d = tb_value[7:0];
        ADDR_W'(AddrTbHi): rdata_d = tb_value[15:8];
        ADDR_W'(AddrIcr):  rdata_d = icr_image;
        ADDR_W'(AddrCra):  rdata_d = ta_cr;
        ADDR_W'(AddrCrb):  rdata_d = tb_cr;
        default:           rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      mask_q  <= '0;
      flags_q <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      flags_q <= flags_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_data = rdata_q;
  assign o_irq  = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        bus_cs;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  rdata;
  logic        irq;
  logic        ta_cs, tb_cs;
  CounterMode  ta_mode, tb_mode;
  logic [15:0] ta_value, tb_value;
  logic        ta_irq, tb_irq;

  int n_checks = 0;
  int n_errors = 0;

  timer_ctrl #(
    .ADDR_W (3)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_cs       (bus_cs),
    .i_we       (bus_we),
    .i_addr     (bus_addr),
    .i_data     (bus_wdata),
    .o_data     (rdata),
    .o_irq      (irq),
    .o_ta_cs    (ta_cs),
    .o_ta_mode  (ta_mode),
    .o_ta_value (ta_value),
    .i_ta_irq   (ta_irq),
    .o_tb_cs    (tb_cs),
    .o_tb_mode  (tb_mode),
    .o_tb_value (tb_value),
    .i_tb_irq   (tb_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [7:0] data);
    bus_cs    = 1'b0;
    bus_we    = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    tick();
    bus_cs    = 1'b1;
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [7:0] data);
    bus_cs   = 1'b0;
    bus_we   = 1'b0;
    bus_addr = addr;
    tick();
    bus_cs   = 1'b1;
    data     = rdata;
  endtask

  task automatic pulse_ta();
    ta_irq = 1'b1;
    tick();
    ta_irq = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    rst_n     = 1'b0;
    bus_cs    = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    ta_irq    = 1'b0;
    tb_irq    = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_ta_cs", 16'(ta_cs), 16'h0);
    check("rst_tb_cs", 16'(tb_cs), 16'h0);
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_data", 16'(rdata), 16'h0);
    check("rst_ta_mode", 16'(ta_mode), 16'(CONTINUOUS));
    check("rst_ta_value", ta_value, 16'h0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("rst_reg%0d", a), 16'(rd), 16'h0);
    end

    // Single-shot start: cs low on the write edge and the LOAD edge, high after
    bus_write(3'(AddrTaLo), 8'h03);
    bus_write(3'(AddrTaHi), 8'h00);
    bus_write(3'(AddrCra), 8'h09);
    check("ss_cs_write_edge", 16'(ta_cs), 16'h0);
    tick();
    check("ss_cs_load", 16'(ta_cs), 16'h0);
    check("ss_value", ta_value, 16'h0003);
    check("ss_mode", 16'(ta_mode), 16'(SINGLE_SHOT));
    tick();
    check("ss_cs_run", 16'(ta_cs), 16'h1);
    pulse_ta();
    check("ss_cs_after_alarm", 16'(ta_cs), 16'h0);
    check("ss_irq_masked", 16'(irq), 16'h0);
    bus_read(3'(AddrCra), rd);
    check("ss_cra_read", 16'(rd), 16'h08);
    bus_read(3'(AddrIcr), rd);
    check("ss_icr_read", 16'(rd), 16'h01);
    tick();
    check("ss_stays_stop", 16'(ta_cs), 16'h0);

    // Continuous: alarms keep the channel running
    bus_write(3'(AddrCra), 8'h01);
    tick();
    check("cont_cs_load", 16'(ta_cs), 16'h0);
    tick();
    check("cont_cs_run", 16'(ta_cs), 16'h1);
    check("cont_mode", 16'(ta_mode), 16'(CONTINUOUS));
    for (int i = 0; i < 3; i++) begin
      pulse_ta();
      check($sformatf("cont_cs_alarm%0d", i), 16'(ta_cs), 16'h1);
      tick();
      check($sformatf("cont_cs_after%0d", i), 16'(ta_cs), 16'h1);
    end
    bus_read(3'(AddrIcr), rd);
    check("cont_icr_read", 16'(rd), 16'h01);

    // Interrupt masking, read-clear and set-beats-clear
    bus_write(3'(AddrIcr), 8'h81);
    check("mask_irq_idle", 16'(irq), 16'h0);
    pulse_ta();
    check("mask_irq_rise", 16'(irq), 16'h1);
    bus_read(3'(AddrIcr), rd);
    check("mask_icr_read", 16'(rd), 16'h81);
    check("mask_irq_cleared", 16'(irq), 16'h0);
    pulse_ta();
    check("mask_irq_rise2", 16'(irq), 16'h1);
    ta_irq = 1'b1;
    bus_read(3'(AddrIcr), rd);
    ta_irq = 1'b0;
    check("setwins_read", 16'(rd), 16'h81);
    check("setwins_irq", 16'(irq), 16'h1);
    bus_read(3'(AddrIcr), rd);
    check("setwins_flag_kept", 16'(rd), 16'h81);
    check("setwins_irq_clear", 16'(irq), 16'h0);
    bus_write(3'(AddrIcr), 8'h01);
    pulse_ta();
    check("late_mask_irq_off", 16'(irq), 16'h0);
    bus_write(3'(AddrIcr), 8'h81);
    check("late_mask_irq_on", 16'(irq), 16'h1);
    bus_read(3'(AddrIcr), rd);
    check("late_mask_read", 16'(rd), 16'h81);

    // Latch change during RUN, then FORCELOAD
    bus_write(3'(AddrTaLo), 8'h05);
    check("fl_value_live", ta_value, 16'h0005);
    check("fl_cs_still_run", 16'(ta_cs), 16'h1);
    bus_write(3'(AddrCra), 8'h11);
    check("fl_cs_write_edge", 16'(ta_cs), 16'h1);
    tick();
    check("fl_cs_load", 16'(ta_cs), 16'h0);
    check("fl_value_load", ta_value, 16'h0005);
    tick();
    check("fl_cs_run", 16'(ta_cs), 16'h1);
    bus_read(3'(AddrCra), rd);
    check("fl_cra_read", 16'(rd), 16'h01);

    // Single-shot alarm coinciding with a START write: write wins, reload
    bus_write(3'(AddrCra), 8'h09);
    check("race_cs_run", 16'(ta_cs), 16'h1);
    ta_irq = 1'b1;
    bus_write(3'(AddrCra), 8'h09);
    ta_irq = 1'b0;
    check("race_cs_load", 16'(ta_cs), 16'h0);
    check("race_irq", 16'(irq), 16'h1);
    tick();
    check("race_cs_run2", 16'(ta_cs), 16'h1);
    bus_read(3'(AddrCra), rd);
    check("race_cra_read", 16'(rd), 16'h09);
    bus_read(3'(AddrIcr), rd);
    check("race_icr_read", 16'(rd), 16'h81);

    // Timer B
    bus_write(3'(AddrTbLo), 8'hAA);
    bus_write(3'(AddrCrb), 8'h01);
    tick();
    tick();
    tb_irq = 1'b1;
    tick();
    tb_irq = 1'b0;
`ifdef GM64_TIMER_B_EN
    check("tb_cs_run", 16'(tb_cs), 16'h1);
    check("tb_value", tb_value, 16'h00AA);
    bus_read(3'(AddrCrb), rd);
    check("tb_crb_read", 16'(rd), 16'h01);
    bus_read(3'(AddrIcr), rd);
    check("tb_icr_read", 16'(rd), 16'h02);
`else
    check("tb_cs_off", 16'(tb_cs), 16'h0);
    check("tb_value_off", tb_value, 16'h0000);
    check("tb_mode_off", 16'(tb_mode), 16'(CONTINUOUS));
    bus_read(3'(AddrCrb), rd);
    check("tb_crb_read", 16'(rd), 16'h00);
    bus_read(3'(AddrTbLo), rd);
    check("tb_lo_read", 16'(rd), 16'h00);
    bus_read(3'(AddrIcr), rd);
    check("tb_icr_read", 16'(rd), 16'h00);
`endif

    // Reset mid-count, with a concurrent bus write
    check("pre_rst_ta_run", 16'(ta_cs), 16'h1);
    rst_n = 1'b0;
    bus_write(3'(AddrCra), 8'h01);
    check("mid_rst_ta_cs", 16'(ta_cs), 16'h0);
    check("mid_rst_tb_cs", 16'(tb_cs), 16'h0);
    check("mid_rst_value", ta_value, 16'h0000);
    check("mid_rst_mode", 16'(ta_mode), 16'(CONTINUOUS));
    check("mid_rst_irq", 16'(irq), 16'h0);
    rst_n = 1'b1;
    bus_read(3'(AddrCra), rd);
    check("post_rst_cra", 16'(rd), 16'h00);
    bus_read(3'(AddrIcr), rd);
    check("post_rst_icr", 16'(rd), 16'h00);
    tick();
    check("post_rst_ta_idle", 16'(ta_cs), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
